// File: rtl/apb_slave_regfile.sv
// APB completer: DEPTH x 32-bit register file with programmable wait states.
// Optional error response when built with `define PSLVERR_EN.
module apb_slave_regfile #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam logic [2:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, wdata_q;
    logic          write_q;
    logic [31:0]   regs [DEPTH];
    logic          pready_q, pready_d;
    logic [31:0]   prdata_q, prdata_d;

    logic [31:0]   addr_cur;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          write_cur;
    logic          err;
    logic          latch;
    logic          go_access;
    logic          commit;

    // In IDLE the setup-phase bus is decoded directly so a zero-wait read can
    // load Prdata on the setup edge; afterwards the latched copy is used.
    always_comb begin
        addr_cur  = (state_q == S_IDLE) ? Paddr  : addr_q;
        write_cur = (state_q == S_IDLE) ? Pwrite : write_q;
        offset    = addr_cur - BASE_ADDR;
        idx       = offset[AW+1:2];
`ifdef PSLVERR_EN
        err       = (offset >= SPAN) || (addr_cur[1:0] != 2'b00);
`else
        err       = 1'b0;
`endif
    end

`ifndef PSLVERR_EN
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        prdata_d  = prdata_q;
        latch     = 1'b0;
        go_access = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Psel && !Penable) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        go_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!Psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    go_access = 1'b1;
                end
            end
            S_ACCESS: begin
                state_d  = S_IDLE;
                pready_d = 1'b0;
                commit   = Psel && Penable && write_q && !err;
            end
            default: begin
                state_d  = S_IDLE;
                pready_d = 1'b0;
            end
        endcase
        if (go_access) begin
            state_d  = S_ACCESS;
            pready_d = 1'b1;
            if (!write_cur) begin
                prdata_d = err ? '0 : regs[idx];
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
            prdata_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
            if (latch) begin
                addr_q  <= Paddr;
                wdata_q <= Pwdata;
                write_q <= Pwrite;
            end
            if (commit) begin
                regs[idx] <= wdata_q;
            end
        end
    end

`ifdef PSLVERR_EN
    logic pslverr_q;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            pslverr_q <= 1'b0;
        end else if (go_access) begin
            pslverr_q <= err;
        end else if (state_q == S_ACCESS) begin
            pslverr_q <= 1'b0;
        end
    end

    assign Pslverr = pslverr_q;
`else
    assign Pslverr = 1'b0;
`endif

    assign Pready = pready_q;
    assign Prdata = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: a zero-wait and a three-wait
// instance, directed vectors, corner sequences and randomized traffic.
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;
`ifdef PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    logic            Hresetn;
    logic [1:0]      psel, penable, pwrite;
    logic [1:0][31:0] paddr, pwdata;
    logic [31:0]     prdata0, prdata1;
    logic            pready0, pready1, pslverr0, pslverr1;

    apb_slave_regfile #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Psel(psel[0]), .Penable(penable[0]),
        .Pwrite(pwrite[0]), .Paddr(paddr[0]), .Pwdata(pwdata[0]),
        .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0)
    );

    apb_slave_regfile #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(BASE)) dut1 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Psel(psel[1]), .Penable(penable[1]),
        .Pwrite(pwrite[1]), .Paddr(paddr[1]), .Pwdata(pwdata[1]),
        .Prdata(prdata1), .Pready(pready1), .Pslverr(pslverr1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem [2][DEPTH];
    logic [31:0] last_rd [2];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [31:0] rd_of(input int d);
        return (d == 0) ? prdata0 : prdata1;
    endfunction

    function automatic logic rdy_of(input int d);
        return (d == 0) ? pready0 : pready1;
    endfunction

    function automatic logic err_of(input int d);
        return (d == 0) ? pslverr0 : pslverr1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = '0;
            for (int i = 0; i < DEPTH; i++) mem[d][i] = '0;
        end
    endfunction

    // Reference behaviour from the address map rules, one call per completed transfer.
    function automatic void model_xfer(input int d, input bit wr, input logic [31:0] addr,
                                       input logic [31:0] data, output logic [31:0] exp_rd,
                                       output bit exp_err);
        logic [31:0] off;
        int          i;
        off     = addr - BASE;
        i       = int'((off / 4) % DEPTH);
        exp_err = ERR_EN && ((off >= DEPTH * 4) || (addr % 4 != 0));
        if (wr) begin
            if (!exp_err) mem[d][i] = data;
        end else begin
            last_rd[d] = exp_err ? 32'h0 : mem[d][i];
        end
        exp_rd = last_rd[d];
    endfunction

    task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] rd,
                            output bit err, output int waits);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = data;
        @(posedge Hclk); #1;
        penable[d] = 1'b1;
        pwrite[d]  = ~wr;
        paddr[d]   = $urandom;
        pwdata[d]  = $urandom;
        waits = 0;
        while (!rdy_of(d) && waits < 20) begin
            @(posedge Hclk); #1;
            waits++;
        end
        rd  = rd_of(d);
        err = err_of(d);
        @(posedge Hclk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        check("pready_one_cycle", 32'(rdy_of(d)), 32'h0);
    endtask

    task automatic run(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd, exp_rd;
        bit          err, exp_err;
        int          waits;
        apb_xfer(d, wr, addr, data, rd, err, waits);
        model_xfer(d, wr, addr, data, exp_rd, exp_err);
        check("prdata", rd, exp_rd);
        check("pslverr", 32'(err), 32'(exp_err));
        check("wait_states", 32'(waits), (d == 0) ? 32'd0 : 32'd3);
    endtask

    initial begin
        logic [31:0] rd, exp_rd, addr;
        bit          err, exp_err;
        int          waits, d, sel;

        tbl[0] = '{1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[1] = '{1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h8000_003C, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0};
        tbl[3] = '{1'b0, 32'h8000_003C, 32'h0,         32'h0BAD_F00D, 1'b0};
        tbl[4] = '{1'b0, 32'h8000_0008, 32'h0,         32'h0, 1'b0};
        tbl[5] = '{1'b1, 32'h8000_0040, 32'h0000_1234, 32'h0, ERR_EN};
`ifdef PSLVERR_EN
        tbl[6] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0, 1'b0};
        tbl[7] = '{1'b0, 32'h8000_0006, 32'h0,         32'h0, 1'b1};
`else
        tbl[6] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0000_1234, 1'b0};
        tbl[7] = '{1'b0, 32'h8000_0006, 32'h0,         32'hDEAD_BEEF, 1'b0};
`endif
        tbl[8] = '{1'b1, 32'h8000_0010, 32'hA5A5_A5A5, tbl[7].exp_rd, 1'b0};
        tbl[9] = '{1'b0, 32'h8000_0010, 32'h0,         32'hA5A5_A5A5, 1'b0};

        psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
        Hresetn = 1'b0;
        model_reset();
        repeat (3) @(posedge Hclk);
        #1;
        check("reset_pready0", 32'(pready0), 32'h0);
        check("reset_pslverr0", 32'(pslverr0), 32'h0);
        check("reset_prdata0", prdata0, 32'h0);
        check("reset_pready1", 32'(pready1), 32'h0);
        check("reset_pslverr1", 32'(pslverr1), 32'h0);
        check("reset_prdata1", prdata1, 32'h0);
        #3 Hresetn = 1'b1;
        @(posedge Hclk); #1;

        for (int i = 0; i < 10; i++) begin
            apb_xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, rd, err, waits);
            model_xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, exp_rd, exp_err);
            check("tbl_prdata", rd, tbl[i].exp_rd);
            check("tbl_pslverr", 32'(err), 32'(tbl[i].exp_err));
            check("tbl_waits", 32'(waits), 32'd0);
        end

        run(1, 1'b1, BASE, 32'h1357_9BDF);
        run(1, 1'b0, BASE, 32'h0);

        for (int i = 0; i < DEPTH; i++) run(0, 1'b1, BASE + 32'(4 * i), 32'(i) * 32'h1111_1111);
        for (int i = 0; i < DEPTH; i++) begin
            apb_xfer(0, 1'b0, BASE + 32'(4 * i), 32'h0, rd, err, waits);
            model_xfer(0, 1'b0, BASE + 32'(4 * i), 32'h0, exp_rd, exp_err);
            check("b2b_prdata", rd, 32'(i) * 32'h1111_1111);
            check("b2b_waits", 32'(waits), 32'd0);
        end

        // Aborted access phase on the zero-wait slave: the write must not land.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = BASE + 32'd12; pwdata[0] = 32'hFFFF_0000;
        @(posedge Hclk); #1;
        psel[0] = 1'b0;
        @(posedge Hclk); #1;
        check("abort_access_pready", 32'(pready0), 32'h0);
        run(0, 1'b0, BASE + 32'd12, 32'h0);

        // Psel dropped mid-wait on the three-wait slave.
        run(1, 1'b1, BASE + 32'd8, 32'h2222_0002);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = BASE + 32'd8; pwdata[1] = 32'h0000_0BAD;
        @(posedge Hclk); #1;
        penable[1] = 1'b1;
        @(posedge Hclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("abort_wait_pready", 32'(pready1), 32'h0);
            @(posedge Hclk); #1;
        end
        run(1, 1'b0, BASE + 32'd8, 32'h0);

        repeat (300) begin
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (sel == 7) addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (sel == 8) addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 63));
            else               addr = $urandom;
            run(d, 1'($urandom_range(0, 1)), addr, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge Hclk); #1;
            end
        end

        // Asynchronous reset while dut0 is in its access phase and dut1 is waiting.
        run(0, 1'b1, BASE, 32'hFEED_0001);
        run(0, 1'b0, BASE, 32'h0);
        run(1, 1'b1, BASE, 32'hFEED_0002);
        run(1, 1'b0, BASE, 32'h0);
        psel = 2'b11; penable = 2'b00; pwrite = 2'b11;
        paddr[0] = BASE + 32'd28; pwdata[0] = 32'h0000_0077;
        paddr[1] = BASE + 32'd20; pwdata[1] = 32'h0000_0055;
        @(posedge Hclk); #1;
        penable = 2'b11;
        check("pre_reset_pready0", 32'(pready0), 32'h1);
        #3 Hresetn = 1'b0;
        #1;
        check("async_pready0", 32'(pready0), 32'h0);
        check("async_pslverr0", 32'(pslverr0), 32'h0);
        check("async_prdata0", prdata0, 32'h0);
        check("async_pready1", 32'(pready1), 32'h0);
        check("async_pslverr1", 32'(pslverr1), 32'h0);
        check("async_prdata1", prdata1, 32'h0);
        psel = '0; penable = '0;
        model_reset();
        @(posedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;
        run(0, 1'b0, BASE + 32'd28, 32'h0);
        run(1, 1'b0, BASE + 32'd20, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
